// File: rtl/alu_sequencer.sv
// Microsequencer that expands LDA/ADD/SUB/OUTA commands into timed control words
// for the accumulator/B-register/ALU datapath and captures the ALU flags.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             abort,
  input  logic             cf_in,
  input  logic             zf_in,
  output logic             nLa,
  output logic             nLb,
  output logic             Ea,
  output logic             Eu,
  output logic             sub,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cf,
  output logic             zf,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned SC_W = 3;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OUTA = 3'b100;

  typedef enum logic [2:0] {
    IDLE, SETTLE, LOAD_A, LOAD_B, EXEC, OUT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             accept;

  logic             nla_d, nlb_d, ea_d, eu_d, sub_d, busy_d, done_d, err_d, ready_d;
  logic             cf_d, zf_d;
  logic [CNT_W-1:0] op_count_d;

  assign accept = cmd_valid && cmd_ready;

  // Next state plus next value of every registered output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    cf_d       = cf;
    zf_d       = zf;
    op_count_d = op_count;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_LDA, OP_ADD, OP_SUB: begin
              state_d = SETTLE;
              cnt_d   = SC_W'(SETTLE_CYC - 1);
            end
            OP_OUTA: state_d = OUT;
            OP_NOP:  state_d = IDLE;
            default: err_d = 1'b1;
          endcase
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = (op_q == OP_LDA) ? LOAD_A : LOAD_B;
        else             cnt_d   = cnt_q - SC_W'(1);
      end
      LOAD_A: state_d = DONE;
      LOAD_B: state_d = EXEC;
      EXEC:   state_d = DONE;
      OUT:    state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          op_count_d = op_count + CNT_W'(1);
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            cf_d = cf_in;
            zf_d = zf_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every transition out of a busy state.
    if (state_q != IDLE && abort) state_d = IDLE;

    nla_d   = !(state_d == LOAD_A || state_d == EXEC);
    nlb_d   = !(state_d == LOAD_B);
    ea_d    = (state_d == OUT);
    eu_d    = (state_d == EXEC);
    sub_d   = (state_d == EXEC) && (op_d == OP_SUB);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      nLa       <= 1'b1;
      nLb       <= 1'b1;
      Ea        <= 1'b0;
      Eu        <= 1'b0;
      sub       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      op_count  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      nLa       <= nla_d;
      nLb       <= nlb_d;
      Ea        <= ea_d;
      Eu        <= eu_d;
      sub       <= sub_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cmd_ready <= ready_d;
      cf        <= cf_d;
      zf        <= zf_d;
      op_count  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: queue-based reference model of the expected control
// words, a per-cycle compare process, and directed literal checks.
module tb_alu_sequencer;

  localparam int unsigned S    = 2;
  localparam int unsigned CW   = 2;
  localparam int          NREC = 8;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LDA = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_OUTA = 3'd4;

  // Control word layout: {done, busy, sub, Eu, Ea, nLb, nLa}
  localparam logic [6:0] W_IDLE = 7'b0000011;
  localparam logic [6:0] W_WAIT = 7'b0100011;
  localparam logic [6:0] W_LDA  = 7'b0100010;
  localparam logic [6:0] W_LDB  = 7'b0100001;
  localparam logic [6:0] W_EXA  = 7'b0101010;
  localparam logic [6:0] W_EXS  = 7'b0111010;
  localparam logic [6:0] W_OUT  = 7'b0100111;
  localparam logic [6:0] W_DONE = 7'b1100011;

  // Recorded-bit positions: {err, done, busy, cmd_ready, sub, Eu, Ea, nLb, nLa}
  localparam int B_NLA = 0, B_NLB = 1, B_EA = 2, B_EU = 3, B_SUB = 4;
  localparam int B_RDY = 5, B_BUSY = 6, B_DONE = 7, B_ERR = 8;

  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0, cf_in = 1'b0, zf_in = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic cmd_ready, nLa, nLb, Ea, Eu, sub, busy, done, err, cf, zf;
  logic [CW-1:0] op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYC(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .abort(abort), .cf_in(cf_in), .zf_in(zf_in),
    .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub), .busy(busy),
    .done(done), .err(err), .cf(cf), .zf(zf), .op_count(op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command becomes a queue of future control words.
  logic [6:0]    m_word;
  logic [6:0]    m_q[$];
  logic          m_ready, m_err, m_cf, m_zf, m_acc;
  logic [CW-1:0] m_cnt;
  logic [2:0]    m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word = W_IDLE; m_q.delete(); m_ready = 1'b0; m_err = 1'b0;
      m_cf = 1'b0; m_zf = 1'b0; m_cnt = '0; m_op = OP_NOP;
    end else begin
      m_acc = m_ready && cmd_valid;
      m_err = m_acc && (cmd_op > OP_OUTA);
      if (m_word[5] && abort) m_q.delete();
      else if (m_word[6]) begin
        m_cnt = m_cnt + 1'b1;
        if (m_op == OP_ADD || m_op == OP_SUB) begin m_cf = cf_in; m_zf = zf_in; end
      end
      if (m_acc) begin
        m_op = cmd_op;
        if (cmd_op == OP_LDA || cmd_op == OP_ADD || cmd_op == OP_SUB)
          for (int i = 0; i < int'(S); i++) m_q.push_back(W_WAIT);
        case (cmd_op)
          OP_LDA:  begin m_q.push_back(W_LDA); m_q.push_back(W_DONE); end
          OP_ADD:  begin m_q.push_back(W_LDB); m_q.push_back(W_EXA); m_q.push_back(W_DONE); end
          OP_SUB:  begin m_q.push_back(W_LDB); m_q.push_back(W_EXS); m_q.push_back(W_DONE); end
          OP_OUTA: begin m_q.push_back(W_OUT); m_q.push_back(W_DONE); end
          default: ;
        endcase
      end
      m_word  = (m_q.size() > 0) ? m_q.pop_front() : W_IDLE;
      m_ready = !m_word[5];
    end
  end

  // Every-cycle comparison of the full output set against the model.
  always @(negedge clk) begin
    check("outputs", {19'd0, err, done, busy, cmd_ready, sub, Eu, Ea, nLb, nLa, cf, zf, op_count},
          {19'd0, m_err, m_word[6], m_word[5], m_ready, m_word[4:0], m_cf, m_zf, m_cnt});
    check("ea_eu_excl", 32'(Ea && Eu), 32'd0);
    check("load_excl", 32'(!nLa && !nLb), 32'd0);
  end

  logic [8:0] rec [1:NREC];

  task automatic issue(input logic [2:0] op, input int abort_cyc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    for (int i = 1; i <= NREC; i++) begin
      @(negedge clk);
      rec[i] = {err, done, busy, cmd_ready, sub, Eu, Ea, nLb, nLa};
      cmd_valid = 1'b0; cmd_op = 3'($urandom); abort = (i == abort_cyc);
    end
    abort = 1'b0;
  endtask

  function automatic int first_at(input int b, input logic v);
    for (int i = 1; i <= NREC; i++) if (rec[i][b] == v) return i;
    return 0;
  endfunction

  function automatic int count_of(input int b, input logic v);
    int n = 0;
    for (int i = 1; i <= NREC; i++) if (rec[i][b] == v) n++;
    return n;
  endfunction

  logic [CW-1:0] seen [0:4];

  initial begin
    int  n;
    bool_pend: begin end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_before_reset", 32'(cmd_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'({cmd_ready, busy, nLa, nLb, Ea, Eu, sub, done, err, cf, zf, op_count}),
             32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}));
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // LDA
    issue(OP_LDA, 0);
    check("lda_nla_cycle", first_at(B_NLA, 1'b0), S + 1);
    check("lda_nla_width", count_of(B_NLA, 1'b0), 1);
    check("lda_done_cycle", first_at(B_DONE, 1'b1), S + 2);
    check("lda_ready_cycle", first_at(B_RDY, 1'b1), S + 3);
    check("lda_count", 32'(op_count), 1);

    // SUB with flags held high
    cf_in = 1'b1; zf_in = 1'b1;
    issue(OP_SUB, 0);
    check("sub_nlb_cycle", first_at(B_NLB, 1'b0), S + 1);
    check("sub_eu_cycle", first_at(B_EU, 1'b1), S + 2);
    check("sub_sel", 32'(rec[S+2][B_SUB]), 1);
    check("sub_exec_nla", 32'(rec[S+2][B_NLA]), 0);
    check("sub_done_cycle", first_at(B_DONE, 1'b1), S + 3);
    check("sub_no_ea", count_of(B_EA, 1'b1), 0);
    check("sub_flags", 32'({cf, zf}), 32'd3);

    // OUTA and an illegal opcode
    cf_in = 1'b0; zf_in = 1'b0;
    issue(OP_OUTA, 0);
    check("outa_ea_cycle", first_at(B_EA, 1'b1), 1);
    check("outa_ea_width", count_of(B_EA, 1'b1), 1);
    check("outa_done_cycle", first_at(B_DONE, 1'b1), 2);
    check("outa_flags_hold", 32'({cf, zf}), 32'd3);
    issue(3'd7, 0);
    check("ill_err_cycle", first_at(B_ERR, 1'b1), 1);
    check("ill_err_width", count_of(B_ERR, 1'b1), 1);
    check("ill_no_done", count_of(B_DONE, 1'b1), 0);
    check("ill_count", 32'(op_count), 3);

    // ADD aborted during LOAD_B
    issue(OP_ADD, S + 1);
    check("abort_no_eu", count_of(B_EU, 1'b1), 0);
    check("abort_no_done", count_of(B_DONE, 1'b1), 0);
    check("abort_idle_next", 32'(rec[S+2][B_BUSY]), 0);
    check("abort_count", 32'(op_count), 3);
    check("abort_flags", 32'({cf, zf}), 32'd3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 3'($urandom_range(0, 7));
      abort     = ($urandom_range(0, 19) == 0);
      cf_in     = 1'($urandom);
      zf_in     = 1'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back LDA after a fresh reset: counter wraps at 2 bits
    #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LDA;
    n = 0;
    begin
      logic pend;
      pend = 1'b0;
      for (int i = 0; i < 80 && n < 5; i++) begin
        @(negedge clk);
        if (pend) begin seen[n] = op_count; n++; pend = 1'b0; end
        if (done) begin pend = 1'b1; if (n == 4) cmd_valid = 1'b0; end
      end
    end
    check("b2b_completed", n, 5);
    check("b2b_cnt0", 32'(seen[0]), 1);
    check("b2b_cnt1", 32'(seen[1]), 2);
    check("b2b_cnt2", 32'(seen[2]), 3);
    check("b2b_cnt3", 32'(seen[3]), 0);
    check("b2b_cnt4", 32'(seen[4]), 1);

    // Reset during EXEC of an ADD
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !Eu; i++) @(negedge clk);
    check("exec_reached", 32'(Eu), 1);
    #1 rst_n = 1'b0;
    #1 check("reset_exec_ctrl", 32'({Eu, nLa, busy, done}), 32'b0100);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
